// File: rtl/cpu_program_loader.sv
`default_nettype none
// ============================================================================
// cpu_program_loader: loads a framed byte stream into CPU memory, gates cpu_reset
// Revision: 1.0
// ============================================================================
module cpu_program_loader #(
  parameter int ADDR_W        = 8,
  parameter int RELEASE_DELAY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  localparam int DLY_W = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
  // The CSUM-accept edge itself counts as the first delay cycle.
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(RELEASE_DELAY - 1);

  localparam logic [2:0] S_ADDR = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        count;
  logic [7:0]        sum;
  logic [DLY_W-1:0]  delay;
  logic              accept;
  logic              csum_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_ADDR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (load_req) begin
      state_nxt = S_ADDR;
    end else begin
      case (state)
        S_ADDR: if (accept) state_nxt = S_LEN;
        S_LEN:  if (accept) state_nxt = (in_data == 8'd0) ? S_CSUM : S_DATA;
        S_DATA: if (accept && count == 8'd1) state_nxt = S_CSUM;
        S_CSUM: if (accept) state_nxt = csum_ok ? S_WAIT : S_ERR;
        S_WAIT: if (delay == '0) state_nxt = S_DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    in_ready = !load_req && (state == S_ADDR || state == S_LEN ||
                             state == S_DATA || state == S_CSUM);
    accept   = in_valid && in_ready;
    csum_ok  = (in_data == sum);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr      <= '0;
      count     <= 8'd0;
      sum       <= 8'd0;
      delay     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // accept is already gated by load_req, so an abort never issues a write
      mem_we <= accept && (state == S_DATA);
      if (load_req) begin
        cpu_reset <= 1'b1;
        done      <= 1'b0;
        err       <= 1'b0;
        sum       <= 8'd0;
      end else begin
        case (state)
          S_ADDR: begin
            if (accept) addr <= ADDR_W'(in_data);
          end
          S_LEN: begin
            if (accept) begin
              count <= in_data;
              sum   <= 8'd0;
            end
          end
          S_DATA: begin
            if (accept) begin
              mem_addr  <= addr;
              mem_wdata <= in_data;
              addr      <= addr + 1'b1;
              sum       <= sum + in_data;
              count     <= count - 8'd1;
            end
          end
          S_CSUM: begin
            if (accept) begin
              if (csum_ok) begin
                done  <= 1'b1;
                delay <= DLY_LOAD;
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_WAIT: begin
            if (delay == '0) cpu_reset <= 1'b0;
            else             delay     <= delay - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_program_loader.sv
`default_nettype none
// tb_cpu_program_loader: directed frames checked every cycle against a frame-level model,
// plus hand-computed literal expectations.
module tb_cpu_program_loader;

  localparam int ADDR_W        = 8;
  localparam int RELEASE_DELAY = 2;
  localparam int DEPTH         = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_req;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  cpu_program_loader #(.ADDR_W(ADDR_W), .RELEASE_DELAY(RELEASE_DELAY)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .done(done), .err(err)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: works on the list of accepted frame bytes
  localparam int P_LOAD = 0;
  localparam int P_GOOD = 1;
  localparam int P_BAD  = 2;

  int                phase = P_LOAD;
  int                since = 0;
  logic [7:0]        fq[$];
  logic              m_we = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [7:0]        m_wdata = 8'd0;
  logic [7:0]        m_mem [DEPTH];
  logic [7:0]        dut_mem [DEPTH];
  int                wr_count = 0;

  function automatic logic [7:0] frame_sum();
    int s = 0;
    for (int i = 2; i < fq.size() - 1; i++) s += int'(fq[i]);
    return 8'(s);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase = P_LOAD; since = 0; fq.delete();
      m_we = 1'b0; m_addr = '0; m_wdata = 8'd0;
    end else begin
      m_we = 1'b0;
      if (load_req) begin
        phase = P_LOAD;
        fq.delete();
      end else if (phase == P_LOAD && in_valid) begin
        fq.push_back(in_data);
        if (fq.size() >= 3 && fq.size() <= 2 + int'(fq[1])) begin
          m_we    = 1'b1;
          m_addr  = ADDR_W'(int'(fq[0]) + fq.size() - 3);
          m_wdata = in_data;
          m_mem[m_addr] = in_data;
        end else if (fq.size() >= 3 && fq.size() == 3 + int'(fq[1])) begin
          phase = (frame_sum() == in_data) ? P_GOOD : P_BAD;
          since = 0;
        end
      end else if (phase == P_GOOD && since < 1000) begin
        since++;
      end
    end
  end

  always @(posedge clk) begin
    if (reset && mem_we) begin
      dut_mem[mem_addr] = mem_wdata;
      wr_count++;
    end
  end

  always begin
    @(posedge clk);
    #2;
    if (reset) begin
      check("in_ready",  in_ready,  (phase == P_LOAD) && !load_req);
      check("mem_we",    mem_we,    m_we);
      check("mem_addr",  mem_addr,  m_addr);
      check("mem_wdata", mem_wdata, m_wdata);
      check("cpu_reset", cpu_reset, !(phase == P_GOOD && since >= RELEASE_DELAY));
      check("done",      done,      phase == P_GOOD);
      check("err",       err,       phase == P_BAD);
    end
  end

  // ---------------- stimulus
  task automatic drive(input logic v, input logic [7:0] d, input logic lr);
    @(negedge clk);
    in_valid = v; in_data = d; load_req = lr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send(input logic [7:0] f[$]);
    foreach (f[i]) drive(1'b1, f[i], 1'b0);
  endtask

  logic [7:0] fr[$];
  int         base;

  initial begin
    reset = 1'b0; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #12;
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(negedge clk); reset = 1'b1;

    // 1: twelve-byte program at address 0
    base = wr_count;
    fr = '{8'h00, 8'h0C, 8'h11, 8'h22, 8'h99, 8'h53, 8'h13, 8'hDB, 8'hDB,
           8'h99, 8'h53, 8'hC4, 8'hC4, 8'hCB, 8'h27};
    send(fr);
    idle(1); #1;
    check("t1_done", done, 1);
    check("t1_cpu_reset_e0", cpu_reset, 1);
    idle(1); #1;
    check("t1_cpu_reset_e1", cpu_reset, 1);
    idle(1); #1;
    check("t1_cpu_reset_e2", cpu_reset, 0);
    check("t1_writes", wr_count - base, 12);
    check("t1_mem0", dut_mem[0], 8'h11);
    check("t1_mem5", dut_mem[5], 8'hDB);
    check("t1_mem11", dut_mem[11], 8'hCB);

    // 2: reload a patch while the CPU is held in reset
    drive(1'b0, 8'h00, 1'b1); #1;
    check("t2_ready_in_abort", in_ready, 0);
    idle(1); #1;
    check("t2_cpu_reset", cpu_reset, 1);
    check("t2_done_clear", done, 0);
    fr = '{8'h11, 8'h02, 8'h05, 8'h01, 8'h06};
    send(fr);
    idle(3); #1;
    check("t2_mem17", dut_mem[17], 8'h05);
    check("t2_mem18", dut_mem[18], 8'h01);
    check("t2_released", cpu_reset, 0);

    // 3: bad checksum
    drive(1'b0, 8'h00, 1'b1);
    fr = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'h00};
    send(fr);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h55, 1'b0);
    #1;
    check("t3_err", err, 1);
    check("t3_done", done, 0);
    check("t3_cpu_reset", cpu_reset, 1);
    check("t3_ready", in_ready, 0);
    check("t3_mem0", dut_mem[0], 8'hAA);

    // 4: address wrap-around
    drive(1'b0, 8'h00, 1'b1);
    fr = '{8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'h06};
    send(fr);
    idle(3); #1;
    check("t4_memFE", dut_mem[8'hFE], 8'h01);
    check("t4_memFF", dut_mem[8'hFF], 8'h02);
    check("t4_mem00", dut_mem[0], 8'h03);
    check("t4_done", done, 1);

    // 5: abort mid-frame (pending write completes), then zero-length frame with gaps
    drive(1'b0, 8'h00, 1'b1);
    fr = '{8'h05, 8'h03, 8'hAA};
    send(fr);
    drive(1'b1, 8'h77, 1'b1);
    idle(1);
    base = wr_count;
    for (int i = 0; i < 3; i++) begin
      idle(int'($urandom_range(0, 2)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++)
        drive(1'b0, 8'($urandom), 1'b0);
      drive(1'b1, 8'h00, 1'b0);
    end
    idle(3); #1;
    check("t5_no_writes", wr_count - base, 0);
    check("t5_done", done, 1);
    check("t5_pending_write", dut_mem[5], 8'hAA);

    // 6: asynchronous reset during S_DATA, then a clean frame
    drive(1'b0, 8'h00, 1'b1);
    fr = '{8'h20, 8'h04, 8'h01, 8'h02};
    send(fr);
    idle(1); #1;
    check("t6_we_before_rst", mem_we, 1);
    reset = 1'b0; #1;
    check("t6_rst_mem_we", mem_we, 0);
    check("t6_rst_mem_addr", mem_addr, 0);
    check("t6_rst_mem_wdata", mem_wdata, 0);
    check("t6_rst_cpu_reset", cpu_reset, 1);
    check("t6_rst_done", done, 0);
    check("t6_rst_err", err, 0);
    @(negedge clk); reset = 1'b1;
    fr = '{8'h30, 8'h02, 8'h0A, 8'h0B, 8'h15};
    send(fr);
    idle(3); #1;
    check("t6_mem30", dut_mem[8'h30], 8'h0A);
    check("t6_mem31", dut_mem[8'h31], 8'h0B);
    check("t6_done", done, 1);
    check("t6_cpu_reset", cpu_reset, 0);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
